// File: rtl/mem_hash_pkg.sv
// Shared defaults and bank-state encoding for the hash memory row buffer.
package mem_hash_pkg;

  localparam int unsigned N_DEF        = 32;
  localparam int unsigned M_DEF        = 32;
  localparam int unsigned ID_WIDTH_DEF = 32;
  localparam int unsigned ADDR_OUT_W   = 6;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Row counter width; a single-row bank still needs one bit of address.
  function automatic int unsigned row_bits(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated read so the output holds while the reader is stalled.
module sdp_ram #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 512
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // NOTE: storage and read register carry no reset, so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_array_buffer.sv
// Double-banked row buffer: fills one M-row bank from upstream while the
// other, once full, is drained in row order to downstream.
module mem_array_buffer
  import mem_hash_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned M        = M_DEF,
  parameter int unsigned ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*N-1:0]       in_data,
  input  logic [ID_WIDTH-1:0]   in_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*N-1:0]       out_data,
  output logic [ADDR_OUT_W-1:0] out_addr,
  output logic [ID_WIDTH-1:0]   out_index,
  output logic                  out_last
);

  localparam int unsigned DW = 16 * N;
  localparam int unsigned RW = row_bits(M);
  localparam int unsigned AW = RW + 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);

  bank_state_e         bank_state_q [2];
  bank_state_e         bank_state_d [2];
  logic [ID_WIDTH-1:0] bank_index_q [2];

  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [RW-1:0]       wr_row_q, wr_row_d;
  logic [RW-1:0]       rd_row_q, rd_row_d;

  logic                out_valid_q, out_valid_d;
  logic [RW-1:0]       out_row_q;
  logic                out_last_q;
  logic [ID_WIDTH-1:0] out_index_q;

  logic accept;
  logic issue;
  logic wr_done;
  logic rd_done;

  assign in_ready = (bank_state_q[wr_ptr_q] != BANK_FULL);
  assign accept   = in_valid && in_ready;
  // A read is launched only if the output register is free or being emptied.
  assign issue    = (bank_state_q[rd_ptr_q] == BANK_FULL) && (!out_valid_q || out_ready);
  assign wr_done  = accept && (wr_row_q == LAST_ROW);
  assign rd_done  = issue && (rd_row_q == LAST_ROW);

  // NOTE: every combinational output gets its default first, so no latch is inferred.
  always_comb begin
    bank_state_d = bank_state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    wr_row_d     = wr_row_q;
    rd_row_d     = rd_row_q;
    out_valid_d  = out_valid_q && !out_ready;

    if (accept) begin
      if (wr_row_q == '0) bank_state_d[wr_ptr_q] = BANK_FILLING;
      if (wr_done) begin
        bank_state_d[wr_ptr_q] = BANK_FULL;
        wr_row_d               = '0;
        wr_ptr_d               = !wr_ptr_q;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    // The writer only touches a non-FULL bank and the reader only a FULL one,
    // so completing a fill and a drain in the same cycle never collide.
    if (issue) begin
      out_valid_d = 1'b1;
      if (rd_done) begin
        bank_state_d[rd_ptr_q] = BANK_EMPTY;
        rd_row_d               = '0;
        rd_ptr_d               = !rd_ptr_q;
      end else begin
        rd_row_d = rd_row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) bank_state_q[b] <= BANK_EMPTY;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_row_q    <= '0;
      rd_row_q    <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      bank_state_q <= bank_state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_row_q     <= wr_row_d;
      rd_row_q     <= rd_row_d;
      out_valid_q  <= out_valid_d;
      if (issue) begin
        out_row_q  <= rd_row_q;
        out_last_q <= (rd_row_q == LAST_ROW);
      end
    end
  end

  // Index side-band follows the data path and is left unreset like the RAM.
  always_ff @(posedge clk) begin
    if (accept && (wr_row_q == '0)) bank_index_q[wr_ptr_q] <= in_index;
    if (issue) out_index_q <= bank_index_q[rd_ptr_q];
  end

  sdp_ram #(
    .AW(AW),
    .DW(DW)
  ) u_ram (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i ({wr_ptr_q, wr_row_q}),
    .wdata_i (in_data),
    .re_i    (issue),
    .raddr_i ({rd_ptr_q, rd_row_q}),
    .rdata_o (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_addr  = ADDR_OUT_W'(out_row_q);
  assign out_index = out_index_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mem_array_buffer.sv
// Directed bench for mem_array_buffer: cycle table for one bank, then
// hand-written sequences checked against an expected-row queue.
module tb_mem_array_buffer;

  localparam int DW = 512;
  localparam int TBL_LEN = 70;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [31:0]   in_index;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [5:0]    out_addr;
  logic [31:0]   out_index;
  logic          out_last;

  always #5 clk = ~clk;

  mem_array_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_index  (in_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_index (out_index),
    .out_last  (out_last)
  );

  typedef struct {
    logic       iv;
    int         row;
    logic       ordy;
    logic       exp_rdy;
    logic       exp_ov;
    logic [5:0] exp_addr;
    logic       exp_last;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [5:0]    addr;
    logic [31:0]   idx;
  } exp_t;

  vec_t tbl [TBL_LEN];
  exp_t sb [$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [5:0]    prev_addr;
  logic [31:0]   prev_index;
  logic          prev_last;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] idx, input int row);
    logic [15:0] r;
    r = 16'(row);
    return {16{idx[15:0], r}};
  endfunction

  task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [31:0] idx, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    in_index  = idx;
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] idx, input int row);
    exp_t e;
    e.data = pat(idx, row);
    e.addr = 6'(row);
    e.idx  = idx;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input bit toggle, input int budget);
    int c;
    c = 0;
    drive(1'b0, '0, '0, 1'b1);
    while (sb.size() != 0 && c < budget) begin
      if (toggle) out_ready = ~out_ready;
      next_cycle();
      c++;
    end
    check(name, sb.size(), 0);
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (prev_stall) begin
        check("hold_data", out_data, prev_data);
        check("hold_addr", out_addr, prev_addr);
        check("hold_index", out_index, prev_index);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_addr", out_addr, e.addr);
          check("out_index", out_index, e.idx);
          check("out_last", out_last, e.addr == 6'd31);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = out_addr;
      prev_index = out_index;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got64;
    bit tp_started;
    int tp_seen;
    int k;
    logic [31:0] idx;

    // Single bank, 32 beats of data=k, index 5, out_ready held high.
    for (int t = 0; t < TBL_LEN; t++) begin
      tbl[t].iv       = (t < 32);
      tbl[t].row      = t;
      tbl[t].ordy     = 1'b1;
      tbl[t].exp_rdy  = 1'b1;
      tbl[t].exp_ov   = (t >= 33) && (t <= 64);
      tbl[t].exp_addr = 6'(t - 33);
      tbl[t].exp_last = (t == 64);
    end

    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_addr", out_addr, 6'd0);
    check("rst_out_last", out_last, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    for (int t = 0; t < TBL_LEN; t++) begin
      drive(tbl[t].iv, DW'(tbl[t].row), 32'h5, tbl[t].ordy);
      @(negedge clk);
      check("tbl_in_ready", in_ready, tbl[t].exp_rdy);
      check("tbl_out_valid", out_valid, tbl[t].exp_ov);
      if (tbl[t].exp_ov) begin
        check("tbl_out_addr", out_addr, tbl[t].exp_addr);
        check("tbl_out_data", out_data, DW'(tbl[t].exp_addr));
        check("tbl_out_index", out_index, 32'h5);
        check("tbl_out_last", out_last, tbl[t].exp_last);
      end
      next_cycle();
    end

    // Backpressure: 65 beats offered with downstream stalled; 64 fit.
    mon_en = 1'b1;
    k = 0;
    for (int c = 0; c < 75; c++) begin
      idx = 32'hA + 32'(k / 32);
      drive(1'b1, pat(idx, k % 32), idx, 1'b0);
      @(negedge clk);
      check("bp_in_ready", in_ready, k < 64);
      if (k < 64) begin
        push(idx, k % 32);
        k++;
      end
      next_cycle();
    end
    @(negedge clk);
    check("bp_stall_valid", out_valid, 1'b1);
    check("bp_stall_addr", out_addr, 6'd0);
    next_cycle();

    got64 = 1'b0;
    for (int c = 0; c < 300 && sb.size() != 0; c++) begin
      drive(!got64, pat(32'hC, 0), 32'hC, 1'b1);
      @(negedge clk);
      if (!got64 && in_ready) got64 = 1'b1;
      next_cycle();
    end
    check("bp_drained", sb.size(), 0);
    check("bp_beat64_taken", got64, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    repeat (5) next_cycle();

    // Reset mid-fill: partial bank must be discarded.
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, pat(32'hD, c), 32'hD, 1'b1);
      next_cycle();
    end
    rst_n = 1'b0;
    drive(1'b1, pat(32'hD, 10), 32'hD, 1'b1);
    @(negedge clk);
    check("rst1_out_valid", out_valid, 1'b0);
    check("rst1_in_ready", in_ready, 1'b1);
    next_cycle();
    rst_n = 1'b1;

    // Fresh bank, then reset partway through its drain.
    for (int c = 0; c < 32; c++) begin
      drive(1'b1, pat(32'hE, c), 32'hE, 1'b1);
      @(negedge clk);
      push(32'hE, c);
      next_cycle();
    end
    drive(1'b0, '0, '0, 1'b1);
    repeat (8) next_cycle();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst2_out_valid", out_valid, 1'b0);
    check("rst2_in_ready", in_ready, 1'b1);
    check("rst2_out_addr", out_addr, 6'd0);
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 10) check("rst2_no_stale", out_valid, 1'b0);
      next_cycle();
    end

    for (int c = 0; c < 32; c++) begin
      drive(1'b1, pat(32'h7, c), 32'h7, 1'b1);
      @(negedge clk);
      push(32'h7, c);
      next_cycle();
    end
    wait_drain("rst2_fresh_drained", 1'b0, 200);

    // Throughput: four back-to-back instances, both sides always ready.
    tp_started = 1'b0;
    tp_seen = 0;
    for (int c = 0; c < 168; c++) begin
      idx = 32'h1 + 32'(c / 32);
      drive(c < 128, pat(idx, c % 32), idx, 1'b1);
      @(negedge clk);
      if (c < 128) begin
        check("tp_in_ready", in_ready, 1'b1);
        push(idx, c % 32);
      end
      if (out_valid) tp_started = 1'b1;
      if (tp_started && tp_seen < 128) check("tp_no_bubble", out_valid, 1'b1);
      if (out_valid) tp_seen++;
      next_cycle();
    end
    check("tp_count", tp_seen, 128);
    check("tp_drained", sb.size(), 0);

    // Stall: out_ready alternates every cycle.
    for (int c = 0; c < 32; c++) begin
      drive(1'b1, pat(32'h9, c), 32'h9, (c % 2) == 0);
      @(negedge clk);
      check("stall_in_ready", in_ready, 1'b1);
      push(32'h9, c);
      next_cycle();
    end
    wait_drain("stall_drained", 1'b1, 300);
    drive(1'b0, '0, '0, 1'b1);
    repeat (3) next_cycle();

    // Collision: second bank's last row lands while addr 31 of the first is out.
    for (int c = 0; c < 65; c++) begin
      if (c < 32) begin
        drive(1'b1, pat(32'h21, c), 32'h21, 1'b1);
      end else if (c == 32) begin
        drive(1'b0, '0, '0, 1'b1);
      end else begin
        drive(1'b1, pat(32'h22, c - 33), 32'h22, 1'b1);
      end
      @(negedge clk);
      if (c < 32) push(32'h21, c);
      if (c > 32) push(32'h22, c - 33);
      if (c == 64) begin
        check("col_out_valid", out_valid, 1'b1);
        check("col_out_addr", out_addr, 6'd31);
        check("col_in_ready", in_ready, 1'b1);
      end
      next_cycle();
    end
    wait_drain("col_drained", 1'b0, 200);
    repeat (5) next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
